crc_engine: RTL and testbench

Parametrised, multi-bit-per-cycle CRC/LFSR engine with framed streaming input and a held, handshaked result. Folds DATA_W bits per clock into a WIDTH-bit register using generator POLY, in either direct (CRC) or augmented (shift-in) feedback form. Supports input/output reflection and a final XOR. Sits between a byte/word stream source and a frame checker or packet builder as the generalised successor to the single-bit LFSR.

---
 rtl/crc_engine.sv | 129 ++++++++++++
 tb/tb_crc_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : crc_engine
// Brief    : Parametrised multi-bit-per-cycle CRC/LFSR engine with framed
//            streaming input and a held, handshaked result.
// Revision : 1.0 - initial release
// ============================================================================
module crc_engine #(
    parameter int unsigned      WIDTH  = 16,
    parameter logic [WIDTH-1:0] POLY   = 16'h8005,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter logic [WIDTH-1:0] XOROUT = '0,
    parameter int unsigned      DATA_W = 8,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0,
    parameter bit               DIRECT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_abort,
    output logic              busy,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [WIDTH-1:0]  crc_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_crc;
    logic [WIDTH-1:0]   r_crc_out;
    logic [WIDTH-1:0]   w_next;
    logic [WIDTH-1:0]   w_refl;
    logic [WIDTH-1:0]   w_result;
    logic [DATA_W-1:0]  w_din;
    logic               w_accept;

    // w_din is arranged so that its MSB is always the first bit folded in
    generate
        if (REFIN) begin : g_refin_rev
            for (genvar i = 0; i < DATA_W; i++) begin : g_bit
                assign w_din[i] = in_data[DATA_W-1-i];
            end
        end else begin : g_refin_pass
            assign w_din = in_data;
        end
    endgenerate

    always_comb begin
        w_next = r_crc;
        for (int i = 0; i < DATA_W; i++) begin
            if (DIRECT) begin
                w_next = {w_next[WIDTH-2:0], 1'b0}
                       ^ ((w_din[DATA_W-1-i] ^ w_next[WIDTH-1]) ? POLY : '0);
            end else begin
                w_next = {w_next[WIDTH-2:0], w_din[DATA_W-1-i]}
                       ^ (w_next[WIDTH-1] ? POLY : '0);
            end
        end
    end

    generate
        for (genvar k = 0; k < WIDTH; k++) begin : g_refout_bit
            assign w_refl[k] = w_next[WIDTH-1-k];
        end
        if (REFOUT) begin : g_refout_on
            assign w_result = w_refl ^ XOROUT;
        end else begin : g_refout_off
            assign w_result = w_next ^ XOROUT;
        end
    endgenerate

    assign crc_valid = (r_state == S_HOLD);
    assign busy      = (r_state == S_RUN);
    assign in_ready  = !crc_valid;
    assign w_accept  = in_valid && in_ready;
    assign crc_out   = r_crc_out;

    // Abort never disturbs a pending result; it only clears the frame in flight
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_RUN: begin
                if (in_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_accept) begin
                    w_state_next = in_last ? S_HOLD : S_RUN;
                end
            end
            S_HOLD: begin
                if (crc_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_crc     <= INIT;
            r_crc_out <= '0;
        end else begin
            r_state <= w_state_next;
            if (in_abort) begin
                r_crc <= INIT;
            end else if (w_accept) begin
                if (in_last) begin
                    r_crc     <= INIT;
                    r_crc_out <= w_result;
                end else begin
                    r_crc <= w_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_engine
// Brief    : Self-checking bench for crc_engine across several CRC presets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Shared byte bus feeding BUYPASS, ARC, CCITT-FALSE and CRC-32 (byte) instances
    logic       v8 = 1'b0, l8 = 1'b0, a8 = 1'b0, cr8 = 1'b1;
    logic [7:0] d8 = 8'h00;
    logic       rdy_a, busy_a, val_a, rdy_b, busy_b, val_b;
    logic       rdy_c, busy_c, val_c, rdy_d, busy_d, val_d;
    logic [15:0] out_a, out_b, out_c;
    logic [31:0] out_d;

    logic        v32 = 1'b0, l32 = 1'b0, a32 = 1'b0, cr32 = 1'b1;
    logic [31:0] d32 = '0;
    logic        rdy32, busy32, val32;
    logic [31:0] out32;

    logic        v4 = 1'b0, l4 = 1'b0, a4 = 1'b0, cr4 = 1'b1;
    logic [0:0]  d4 = '0;
    logic        rdy4, busy4, val4;
    logic [3:0]  out4;

    crc_engine dut_a (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy_a), .in_data(d8),
        .in_last(l8), .in_abort(a8), .busy(busy_a), .crc_valid(val_a),
        .crc_ready(cr8), .crc_out(out_a));

    crc_engine #(.REFIN(1'b1), .REFOUT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy_b), .in_data(d8),
        .in_last(l8), .in_abort(a8), .busy(busy_b), .crc_valid(val_b),
        .crc_ready(cr8), .crc_out(out_b));

    crc_engine #(.POLY(16'h1021), .INIT(16'hFFFF)) dut_c (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy_c), .in_data(d8),
        .in_last(l8), .in_abort(a8), .busy(busy_c), .crc_valid(val_c),
        .crc_ready(cr8), .crc_out(out_c));

    crc_engine #(.WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                 .XOROUT(32'hFFFFFFFF), .DATA_W(8), .REFIN(1'b1), .REFOUT(1'b1)) dut_d (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy_d), .in_data(d8),
        .in_last(l8), .in_abort(a8), .busy(busy_d), .crc_valid(val_d),
        .crc_ready(cr8), .crc_out(out_d));

    crc_engine #(.WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                 .XOROUT(32'hFFFFFFFF), .DATA_W(32), .REFIN(1'b1), .REFOUT(1'b1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
        .in_last(l32), .in_abort(a32), .busy(busy32), .crc_valid(val32),
        .crc_ready(cr32), .crc_out(out32));

    crc_engine #(.WIDTH(4), .POLY(4'h3), .INIT(4'h0), .XOROUT(4'h0),
                 .DATA_W(1), .DIRECT(1'b0)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .in_last(l4), .in_abort(a4), .busy(busy4), .crc_valid(val4),
        .crc_ready(cr4), .crc_out(out4));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Bit-serial reference: elements carry bw bits each, consumed in REFIN order
    function automatic logic [31:0] model_crc(input int width, input logic [31:0] poly,
            input logic [31:0] init, input logic [31:0] xorout, input bit refin,
            input bit refout, input bit direct, input int bw, input logic [7:0] q[$]);
        logic [63:0] mask = (64'd1 << width) - 64'd1;
        logic [31:0] c = init;
        logic [31:0] r = '0;
        logic        b, m;
        foreach (q[i]) begin
            for (int k = 0; k < bw; k++) begin
                b = refin ? q[i][k] : q[i][bw-1-k];
                m = c[width-1];
                if (direct) c = ((c << 1) ^ ((b ^ m) ? poly : 32'h0)) & mask[31:0];
                else        c = (((c << 1) | {31'h0, b}) ^ (m ? poly : 32'h0)) & mask[31:0];
            end
        end
        if (refout) begin
            for (int k = 0; k < width; k++) r[k] = c[width-1-k];
        end else begin
            r = c;
        end
        return (r ^ xorout) & mask[31:0];
    endfunction

    // Transaction-level model of the shared byte bus
    logic [7:0]  fq[$];
    bit          started = 1'b0;
    bit          exp_busy = 1'b0, exp_valid = 1'b0;
    logic [31:0] exp_a = '0, exp_b = '0, exp_c = '0, exp_d = '0;

    always @(posedge clk) begin : p_model
        bit acc, hs;
        if (rst) begin
            fq.delete();
            started   <= 1'b1;
            exp_busy  <= 1'b0;
            exp_valid <= 1'b0;
            exp_a <= '0; exp_b <= '0; exp_c <= '0; exp_d <= '0;
        end else begin
            acc = v8 && !exp_valid;
            hs  = exp_valid && cr8;
            if (a8) begin
                fq.delete();
                exp_busy <= 1'b0;
            end else if (acc) begin
                fq.push_back(d8);
                if (l8) begin
                    exp_a <= model_crc(16, 32'h8005, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8, fq);
                    exp_b <= model_crc(16, 32'h8005, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 8, fq);
                    exp_c <= model_crc(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, 1'b1, 8, fq);
                    exp_d <= model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                       1'b1, 1'b1, 1'b1, 8, fq);
                    exp_valid <= 1'b1;
                    exp_busy  <= 1'b0;
                    fq.delete();
                end else begin
                    exp_busy <= 1'b1;
                end
            end
            if (hs) exp_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", {31'h0, busy_a}, {31'h0, exp_busy});
            chk("crc_valid", {31'h0, val_a}, {31'h0, exp_valid});
            chk("in_ready", {31'h0, rdy_a}, {31'h0, !exp_valid});
            chk("valid_arc", {31'h0, val_b}, {31'h0, exp_valid});
            chk("valid_ccitt", {31'h0, val_c}, {31'h0, exp_valid});
            chk("valid_crc32", {31'h0, val_d}, {31'h0, exp_valid});
            chk("out_buypass", {16'h0, out_a}, exp_a);
            chk("out_arc", {16'h0, out_b}, exp_b);
            chk("out_ccitt", {16'h0, out_c}, exp_c);
            chk("out_crc32", out_d, exp_d);
        end
    end

    // Called at a negedge; returns at the negedge after the byte was accepted
    task automatic send(input logic [7:0] b, input bit last);
        int n = 0;
        v8 = 1'b1; d8 = b; l8 = last;
        while (!rdy_a) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("send_timeout", 32'h0, 32'h1);
                break;
            end
        end
        @(negedge clk);
        v8 = 1'b0; l8 = 1'b0;
    endtask

    task automatic send_bytes(input string s, input bit last_at_end);
        for (int i = 0; i < s.len(); i++)
            send(s[i], last_at_end && (i == s.len() - 1));
    endtask

    initial begin : p_main
        logic [7:0] q[$];
        logic [3:0] seq[4] = '{4'h1, 4'h2, 4'h4, 4'h8};
        logic [7:0] bits[5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'h0, busy_a}, 32'h0);
        chk("rst_valid", {31'h0, val_a}, 32'h0);
        chk("rst_ready", {31'h0, rdy_a}, 32'h1);
        chk("rst_out", {16'h0, out_a}, 32'h0);

        send_bytes("123456789", 1'b1);
        chk("buypass_lit", {16'h0, out_a}, 32'hFEE8);
        chk("arc_lit", {16'h0, out_b}, 32'hBB3D);
        chk("ccitt_lit", {16'h0, out_c}, 32'h29B1);
        chk("crc32_lit", out_d, 32'hCBF43926);
        chk("model_buypass_lit", exp_a, 32'hFEE8);
        chk("model_crc32_lit", exp_d, 32'hCBF43926);
        chk("latency_valid", {31'h0, val_a}, 32'h1);
        @(negedge clk);

        // Backpressure on a result while the next frame's first byte waits
        cr8 = 1'b0;
        send_bytes("12345678", 1'b1);
        v8 = 1'b1; d8 = "1"; l8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a8 = (i == 2);
            @(negedge clk);
            chk("bp_in_ready", {31'h0, rdy_a}, 32'h0);
        end
        a8 = 1'b0;
        cr8 = 1'b1;
        send_bytes("123456789", 1'b1);
        chk("bp_next_frame", {16'h0, out_a}, 32'hFEE8);
        @(negedge clk);

        // Abort with a simultaneous valid byte drops the partial frame
        send_bytes("1234", 1'b0);
        v8 = 1'b1; d8 = "5"; a8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0; a8 = 1'b0;
        send_bytes("123456789", 1'b1);
        chk("abort_frame", {16'h0, out_a}, 32'hFEE8);
        @(negedge clk);

        // Reset mid-frame
        send_bytes("123", 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", {31'h0, busy_a}, 32'h0);
        chk("rst_mid_valid", {31'h0, val_a}, 32'h0);
        send_bytes("123456789", 1'b1);
        chk("rst_next_frame", {16'h0, out_a}, 32'hFEE8);
        @(negedge clk);

        // CRC-32 with 32-bit words must match the byte-serial result
        v32 = 1'b1; d32 = 32'h34333231; l32 = 1'b0;
        @(negedge clk);
        d32 = 32'h38373635; l32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0; l32 = 1'b0;
        q = '{"1", "2", "3", "4", "5", "6", "7", "8"};
        chk("crc32_w32_valid", {31'h0, val32}, 32'h1);
        chk("crc32_w32", out32, model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                          1'b1, 1'b1, 1'b1, 8, q));

        // Augmented-form 4-bit LFSR, one bit per cycle
        for (int i = 0; i < 5; i++) begin
            v4 = 1'b1; d4 = bits[i][0:0]; l4 = (i == 4);
            @(negedge clk);
            if (i < 4) chk("lfsr_reg", {28'h0, dut4.r_crc}, {28'h0, seq[i]});
        end
        v4 = 1'b0; l4 = 1'b0;
        q = '{bits[0], bits[1], bits[2], bits[3], bits[4]};
        chk("lfsr_out_lit", {28'h0, out4}, 32'h3);
        chk("lfsr_out_model", {28'h0, out4}, model_crc(4, 32'h3, 32'h0, 32'h0,
                                                       1'b0, 1'b0, 1'b0, 1, q));
        chk("lfsr_valid", {31'h0, val4}, 32'h1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
